multicycle_control_fsm: RTL and testbench

//  Sequencing controller for the multicycle RV32I core variant. Replaces per-instruction single-cycle decode with a

---
 rtl/multicycle_control_fsm.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencing controller.
// A Moore/Mealy FSM drives the shared ALU, the unified memory port and the
// IR/PC/register-file write enables. It also contains a memory-wait watchdog
// and a sticky trap state that only reset can leave.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    // Opcode encodings shared with the single-cycle decoder
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_OPIMM  = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter only needs to hold MEM_TIMEOUT-1 waits before the trap fires
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    logic          trap_q;
    logic [1:0]    cause_q;
    logic [1:0]    next_cause;
    logic          pc_update;
    logic          branch;
    logic          in_mem;
    logic          timeout_hit;

    assign in_mem      = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout_hit = (MEM_TIMEOUT > 0) && in_mem && !mem_ready && (wait_cnt == WAIT_LIMIT);

    // State register, wait counter and sticky trap flag; reset aborts any instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 2'b00;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
            if ((state != S_TRAP) && (next_state == S_TRAP)) begin
                trap_q  <= 1'b1;
                cause_q <= next_cause;
            end
        end
    end

    // Wait counter counts unanswered memory cycles and clears otherwise, so every
    // fresh memory state starts from zero
    always_comb begin
        wait_cnt_next = '0;
        if ((MEM_TIMEOUT > 0) && in_mem && !mem_ready) begin
            wait_cnt_next = wait_cnt + CW'(1);
        end
    end

    // Next-state and control outputs; every output is forced low while reset is held
    always_comb begin
        next_state = state;
        next_cause = 2'b00;
        pc_update  = 1'b0;
        branch     = 1'b0;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        ImmSrc     = IMM_NONE;
        instr_done = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    pc_update  = 1'b1;
                    ALUSrcB    = 2'b10;
                    ResultSrc  = 2'b10;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_OPIMM, OP_JALR: ImmSrc = IMM_I;
                    OP_AUIPC, OP_LUI:           ImmSrc = IMM_U;
                    OP_STORE:                   ImmSrc = IMM_S;
                    OP_BRANCH:                  ImmSrc = IMM_B;
                    OP_JAL:                     ImmSrc = IMM_J;
                    default:                    ImmSrc = IMM_NONE;
                endcase
                // AUIPC already has OldPC+imm in ALUOut here, so it goes straight to writeback
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_OPIMM:          next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_ALUWB;
                    default: begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op == OP_STORE) begin
                    ImmSrc     = IMM_S;
                    next_state = S_MEMWRITE;
                end else begin
                    ImmSrc     = IMM_I;
                    next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUOp      = 2'b10;
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                ImmSrc     = IMM_I;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = 2'b00;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUOp      = 2'b01;
                ResultSrc  = 2'b00;
                branch     = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_I;
                ALUOp      = 2'b00;
                next_state = S_JAL;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b00;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ImmSrc     = IMM_U;
                ResultSrc  = 2'b11;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_TRAP;
                next_cause = CAUSE_ILLEGAL;
            end
        endcase

        // Watchdog expiry overrides whatever the memory state wanted to do
        if (timeout_hit) begin
            next_state = S_TRAP;
            next_cause = CAUSE_TIMEOUT;
        end

        PCWrite    = pc_update | (branch & branch_taken);
        trap       = trap_q;
        trap_cause = cause_q;

        if (!rst_n) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            ImmSrc     = 3'b000;
            instr_done = 1'b0;
            trap       = 1'b0;
            trap_cause = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm.
// A memory responder answers requests after a planned number of wait cycles.
// Each issued instruction pushes its expected outcome into a scoreboard queue.
// A monitor accumulates observed behaviour per instruction and pops the queue
// on retirement or trap.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    localparam int TIMEOUT = 16;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_OPIMM  = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       instr_done, trap;
    logic [1:0] trap_cause;

    multicycle_control_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_trap;
        int cause;
        int cycles;
        int regw;
        int pcw;
        int memw;
        int memreq;
        int rsrc;
        int aluf;
        int aluc;
        int imm;
    } exp_t;

    exp_t expq[$];
    int   waitq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_R, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL};
    endfunction

    // Reference model: instruction-level outcome from opcode, fetch waits,
    // data-memory waits and branch outcome
    function automatic exp_t model(input logic [6:0] o, input int fw, input int mw, input bit bt);
        exp_t e;
        bit   is_mem;
        int   base;
        e = '{default: 0};
        is_mem = (o == OP_LOAD) || (o == OP_STORE);
        case (o)
            OP_LOAD, OP_OPIMM, OP_JALR: e.imm = 0;
            OP_AUIPC, OP_LUI:           e.imm = 1;
            OP_STORE:                   e.imm = 2;
            OP_BRANCH:                  e.imm = 3;
            OP_JAL:                     e.imm = 4;
            default:                    e.imm = 7;
        endcase
        if (fw >= TIMEOUT) begin
            e.is_trap = 1; e.cause = 2; e.cycles = TIMEOUT;
            return e;
        end
        if (!is_legal(o)) begin
            e.is_trap = 1; e.cause = 1; e.cycles = fw + 2;
            return e;
        end
        if (is_mem && mw >= TIMEOUT) begin
            e.is_trap = 1; e.cause = 2; e.cycles = fw + 3 + TIMEOUT;
            return e;
        end
        case (o)
            OP_LOAD:            base = 5;
            OP_JALR:            base = 5;
            OP_BRANCH, OP_LUI:  base = 3;
            OP_AUIPC:           base = 3;
            default:            base = 4;
        endcase
        e.cycles = base + fw + (is_mem ? mw : 0);
        e.regw   = (o == OP_STORE || o == OP_BRANCH) ? 0 : 1;
        e.pcw    = 1 + ((o == OP_JAL || o == OP_JALR) ? 1 : 0) + ((o == OP_BRANCH && bt) ? 1 : 0);
        e.memw   = (o == OP_STORE) ? mw + 1 : 0;
        e.memreq = fw + 1 + (is_mem ? mw + 1 : 0);
        e.rsrc   = (o == OP_LOAD) ? 1 : (o == OP_LUI) ? 3 : 0;
        e.aluf   = (o == OP_R || o == OP_OPIMM) ? 1 : 0;
        e.aluc   = (o == OP_BRANCH) ? 1 : 0;
        return e;
    endfunction

    // Queue the expectation and memory wait plan, then drive the opcode
    task automatic applyStimulus(input logic [6:0] o, input int fw, input int mw, input bit bt);
        exp_t e;
        e = model(o, fw, mw, bt);
        expq.push_back(e);
        waitq.push_back(fw);
        if ((o == OP_LOAD || o == OP_STORE) && fw < TIMEOUT) waitq.push_back(mw);
        op = o;
        branch_taken = bt;
    endtask

    // Bounded wait for retirement or trap; leaves time just after the next rising edge
    task automatic waitDone(output bit stopped);
        bit seen;
        seen = 0;
        stopped = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk); #3;
            if (instr_done) seen = 1;
            else if (trap) begin seen = 1; stopped = 1; end
        end
        if (!seen) begin
            checkOutput("completion_within_budget", int'(seen), 1);
            stopped = 1;
        end
        @(posedge clk); #1;
    endtask

    // Enter reset and discard any pending expectations
    task automatic enterReset();
        rst_n = 1'b0;
        expq.delete();
        waitq.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Issue one instruction, releasing reset if it is held; traps are checked for stickiness then reset
    task automatic issue(input logic [6:0] o, input int fw, input int mw, input bit bt);
        bit   stopped;
        exp_t e;
        e = model(o, fw, mw, bt);
        applyStimulus(o, fw, mw, bt);
        rst_n = 1'b1;
        waitDone(stopped);
        if (stopped) begin
            if (trap) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk); #3;
                    checkOutput("trap_no_mem_req", int'(mem_req), 0);
                    checkOutput("trap_sticky", int'({trap, trap_cause}), int'({1'b1, 2'(e.cause)}));
                end
                @(posedge clk); #1;
            end
            enterReset();
        end
    endtask

    // Memory responder: holds mem_ready low for the planned number of waits per access
    initial begin
        bit active;
        int left;
        active = 0;
        left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1;
                    left = (waitq.size() > 0) ? waitq.pop_front() : 0;
                end
                if (left > 0) begin
                    mem_ready = 1'b0;
                    left--;
                end else begin
                    mem_ready = 1'b1;
                    active = 0;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: per-cycle invariants, per-instruction accumulation, scoreboard pops
    initial begin
        int   cyc, regw, pcw, memw, memreq, rsrc, aluf, aluc;
        bit   prev_ir, parked;
        exp_t e;
        cyc = 0; regw = 0; pcw = 0; memw = 0; memreq = 0; rsrc = 0; aluf = 0; aluc = 0;
        prev_ir = 0; parked = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                checkOutput("reset_outputs_zero",
                    int'({mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
                          ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, trap, trap_cause}), 0);
                cyc = 0; regw = 0; pcw = 0; memw = 0; memreq = 0; rsrc = 0; aluf = 0; aluc = 0;
                prev_ir = 0; parked = 0;
            end else if (!parked) begin
                checkOutput("write_enables_exclusive", int'(IRWrite) + int'(RegWrite) + int'(MemWrite) > 1, 0);
                checkOutput("memwrite_needs_req_adr", int'(MemWrite && !(mem_req && AdrSrc)), 0);
                if (prev_ir && expq.size() > 0) checkOutput("decode_immsrc", int'(ImmSrc), expq[0].imm);
                prev_ir = IRWrite;
                if (trap) begin
                    parked = 1;
                    checkOutput("scoreboard_nonempty", int'(expq.size() > 0), 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        checkOutput("event_is_trap", int'(trap), int'(e.is_trap));
                        checkOutput("trap_cause", int'(trap_cause), e.cause);
                        checkOutput("cycles_to_trap", cyc, e.cycles);
                    end
                end else begin
                    cyc++;
                    regw   += int'(RegWrite);
                    pcw    += int'(PCWrite);
                    memw   += int'(MemWrite);
                    memreq += int'(mem_req);
                    aluf   += int'(ALUOp == 2'b10);
                    aluc   += int'(ALUOp == 2'b01);
                    if (RegWrite) rsrc = int'(ResultSrc);
                    if (instr_done) begin
                        checkOutput("scoreboard_nonempty", int'(expq.size() > 0), 1);
                        if (expq.size() > 0) begin
                            e = expq.pop_front();
                            checkOutput("event_is_trap", int'(trap), int'(e.is_trap));
                            checkOutput("latency", cyc, e.cycles);
                            checkOutput("regwrite_cycles", regw, e.regw);
                            checkOutput("pcwrite_cycles", pcw, e.pcw);
                            checkOutput("memwrite_cycles", memw, e.memw);
                            checkOutput("mem_req_cycles", memreq, e.memreq);
                            checkOutput("aluop_funct_cycles", aluf, e.aluf);
                            checkOutput("aluop_branch_cycles", aluc, e.aluc);
                            if (e.regw > 0) checkOutput("writeback_resultsrc", rsrc, e.rsrc);
                        end
                        cyc = 0; regw = 0; pcw = 0; memw = 0; memreq = 0; rsrc = 0; aluf = 0; aluc = 0;
                    end
                end
            end
        end
    end

    // Global time guard so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] aborted");
    end

    // Main stimulus sequence: directed cases, reset mid-store, then random program
    initial begin
        logic [6:0] legal_ops [9];
        logic [6:0] o;
        bit         stopped;
        legal_ops = '{OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_R, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL};

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] directed instruction sequences");
        issue(OP_R, 0, 0, 0);
        issue(OP_LOAD, 0, 3, 0);
        issue(OP_BRANCH, 0, 0, 1);
        issue(OP_BRANCH, 0, 0, 0);
        issue(OP_JALR, 0, 0, 0);
        issue(OP_JAL, 1, 0, 0);
        issue(OP_LUI, 0, 0, 0);
        issue(OP_AUIPC, 0, 0, 0);
        issue(OP_STORE, 2, 1, 0);
        issue(OP_OPIMM, TIMEOUT - 1, 0, 0);
        issue(OP_LOAD, 0, TIMEOUT - 1, 0);
        issue(7'h7F, 0, 0, 0);
        issue(OP_R, TIMEOUT, 0, 0);
        issue(OP_STORE, 1, TIMEOUT, 0);

        $display("[TB] reset during a pending store");
        applyStimulus(OP_STORE, 0, 8, 0);
        rst_n = 1'b1;
        stopped = 1;
        for (int k = 0; k < 20 && stopped; k++) begin
            @(negedge clk); #3;
            if (MemWrite) stopped = 0;
        end
        checkOutput("store_reaches_memwrite", int'(MemWrite), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        expq.delete();
        waitq.delete();
        @(negedge clk); #3;
        checkOutput("reset_drops_memwrite", int'({mem_req, MemWrite}), 0);
        @(posedge clk); #1;
        applyStimulus(OP_R, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk); #3;
        checkOutput("fetch_after_reset", int'({mem_req, AdrSrc, MemWrite, RegWrite}), int'(4'b1000));
        waitDone(stopped);
        if (stopped) enterReset();

        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                o = 7'($urandom_range(0, 127));
                while (is_legal(o)) o = 7'($urandom_range(0, 127));
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
            end
            issue(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
